// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fa_cell.sv
// Reference 1-bit full-adder cell: y0 is the sum bit, y1 the carry-out (majority).
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y0,
  output logic y1
);

  assign y0 = a ^ b ^ c;
  assign y1 = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequences one external full-adder cell over WIDTH bits, LSB first, with a
// start/done handshake toward the requester.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_y0,
  input  logic             fa_y1,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is only looked at in IDLE; a start seen in RUN or DONE is
  // dropped, not queued. done is a single-cycle pulse, after which sum/cout
  // stay stable until the next accepted start.
  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  assign fsm_state = state;

  always_comb begin
    fa_a = 1'b0;
    fa_b = 1'b0;
    fa_c = 1'b0;
    if (state == RUN) begin
      fa_a = a_sh[0];
      fa_b = b_sh[0];
      fa_c = carry;
    end
    // Each new sum bit enters at the MSB, so after WIDTH shifts bit i sits at index i.
    sum_next = sum >> 1;
    sum_next[WIDTH-1] = fa_y0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_next;
          carry <= fa_y1;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            cout  <= fa_y1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
